// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side target for the core's load/store port. It holds a word-organised
// data RAM behind a valid/ready request channel and a valid/ready response
// channel. Only one transaction is outstanding at a time. Each access waits a
// configurable number of cycles before its response is presented.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      wait cycles between request acceptance and response (0..15)
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous, active-low reset (RAM contents are kept)
//   req_valid_i  request present
//   req_ready_o  block can accept a request (high only in IDLE)
//   req_write_i  1 = store, 0 = load
//   req_addr_i   byte address
//   req_wdata_i  store data
//   req_be_i     store byte enables, bit k covers bits 8k+7:8k
//   rsp_valid_o  response present
//   rsp_ready_i  initiator accepts the response
//   rsp_rdata_o  load data, 0 for stores and errors
//   rsp_err_o    access was misaligned or out of range
//   busy_o       high in any state other than IDLE
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [3:0]         count;
    logic               lat_write;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               enter_resp;
    logic               acc_write;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [3:0]         acc_be;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_index;
    logic [31:0]        rdata_next;
    logic               ram_we;

    // With zero latency the access executes on the accept edge itself, so the
    // live request fields are used while in IDLE; otherwise the latched copy.
    always_comb begin
        accept     = req_valid_i && req_ready_o;
        enter_resp = ((state == IDLE) && accept && (LATENCY == 0)) ||
                     ((state == WAIT) && (count == 4'd0));
        if (state == IDLE) begin
            acc_write = req_write_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
            acc_be    = req_be_i;
        end else begin
            acc_write = lat_write;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
        acc_err    = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:IDX_W+2]);
        acc_index  = acc_addr[IDX_W+1:2];
        rdata_next = (!acc_write && !acc_err) ? mem[acc_index] : 32'd0;
        ram_we     = enter_resp && acc_write && !acc_err && rst_i;
    end

    // RAM storage is not reset; the write is gated by rst_i so a store that is
    // pending when reset arrives is never committed.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_be[k]) begin
                    mem[acc_index][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs. The
    // response fields are loaded on the edge entering RESP and held until the
    // initiator takes them; leaving RESP zeroes them again.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            count       <= 4'd0;
            lat_write   <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            lat_be      <= 4'd0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write   <= req_write_i;
                        lat_addr    <= req_addr_i;
                        lat_wdata   <= req_wdata_i;
                        lat_be      <= req_be_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (LATENCY == 0) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= rdata_next;
                            rsp_err_o   <= acc_err;
                        end else begin
                            state <= WAIT;
                            count <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= rdata_next;
                        rsp_err_o   <= acc_err;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= 32'd0;
                        rsp_err_o   <= 1'b0;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. Two instances are built: one with
// LATENCY=2 and one with LATENCY=0, both with DEPTH_WORDS=128. They share the
// clock, reset and request fields; sel0 steers req_valid to one of them and
// selects which instance's outputs are observed. A word-array memory model
// per instance predicts every response from the access rules.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    logic        obs_req_ready, obs_rsp_valid, obs_rsp_err, obs_busy;
    logic [31:0] obs_rsp_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [2][DEPTH];
    logic [31:0] last_rdata;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid && !sel0),
        .req_ready_o (a_req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (a_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (a_rsp_rdata),
        .rsp_err_o   (a_rsp_err),
        .busy_o      (a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid && sel0),
        .req_ready_o (b_req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (b_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (b_rsp_rdata),
        .rsp_err_o   (b_rsp_err),
        .busy_o      (b_busy)
    );

    // Observation mux: look at whichever instance is currently selected.
    assign obs_req_ready = sel0 ? b_req_ready : a_req_ready;
    assign obs_rsp_valid = sel0 ? b_rsp_valid : a_rsp_valid;
    assign obs_rsp_err   = sel0 ? b_rsp_err   : a_rsp_err;
    assign obs_busy      = sel0 ? b_busy      : a_busy;
    assign obs_rsp_rdata = sel0 ? b_rsp_rdata : a_rsp_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic randomizeReq();
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // One complete transaction on the selected instance. hold is the number
    // of RESP cycles with rsp_ready low; hold=0 raises rsp_ready before the
    // response appears. Ignored request pulses are thrown in while busy.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int hold);
        int          m;
        int          lat;
        int          n;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rdata;

        m         = sel0 ? 1 : 0;
        lat       = sel0 ? 0 : 2;
        exp_err   = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
        idx       = exp_err ? 0 : int'(addr / 4);
        exp_rdata = (!wr && !exp_err) ? model[m][idx] : 32'd0;

        checkOutput("ready_before_req", 32'(obs_req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = (hold == 0);

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            randomizeReq();
            req_valid = (n == 1) ? 1'($urandom) : 1'b0;
            if (!req_valid) req_write = 1'b1;
        end while (!obs_rsp_valid && n < 40);
        req_valid = 1'b0;

        checkOutput("latency_edges", 32'(n), 32'(lat + 1));
        checkOutput("rsp_rdata", obs_rsp_rdata, exp_rdata);
        checkOutput("rsp_err", 32'(obs_rsp_err), 32'(exp_err));
        checkOutput("busy_in_resp", 32'(obs_busy), 32'd1);
        checkOutput("ready_in_resp", 32'(obs_req_ready), 32'd0);
        last_rdata = obs_rsp_rdata;

        if (wr && !exp_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) model[m][idx][8*k +: 8] = wdata[8*k +: 8];
            end
        end

        for (int i = 0; i < hold; i++) begin
            randomizeReq();
            req_valid = 1'($urandom);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            checkOutput("hold_valid", 32'(obs_rsp_valid), 32'd1);
            checkOutput("hold_rdata", obs_rsp_rdata, exp_rdata);
            checkOutput("hold_err", 32'(obs_rsp_err), 32'(exp_err));
            checkOutput("hold_ready", 32'(obs_req_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("exit_valid", 32'(obs_rsp_valid), 32'd0);
        checkOutput("exit_rdata", obs_rsp_rdata, 32'd0);
        checkOutput("exit_err", 32'(obs_rsp_err), 32'd0);
        checkOutput("exit_busy", 32'(obs_busy), 32'd0);
        checkOutput("exit_ready", 32'(obs_req_ready), 32'd1);
    endtask

    task automatic checkIdleBoth(input string tag);
        for (int s = 0; s < 2; s++) begin
            sel0 = 1'(s);
            #0;
            checkOutput({tag, "_ready"}, 32'(obs_req_ready), 32'd1);
            checkOutput({tag, "_valid"}, 32'(obs_rsp_valid), 32'd0);
            checkOutput({tag, "_rdata"}, obs_rsp_rdata, 32'd0);
            checkOutput({tag, "_err"}, 32'(obs_rsp_err), 32'd0);
            checkOutput({tag, "_busy"}, 32'(obs_busy), 32'd0);
        end
    endtask

    // Main sequence: reset, model fill, directed cases, then random traffic.
    initial begin
        logic [31:0] addr;
        logic [31:0] saved;

        sel0      = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        randomizeReq();
        req_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            randomizeReq();
            req_valid = 1'($urandom);
            rsp_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        checkIdleBoth("reset");
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        checkIdleBoth("post_reset");

        for (int s = 0; s < 2; s++) begin
            sel0 = 1'(s);
            for (int w = 0; w < DEPTH; w++) begin
                applyStimulus(1'b1, 32'(w * 4), $urandom, 4'hF, 0);
            end
        end

        sel0 = 1'b0;
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
        checkOutput("load_deadbeef", last_rdata, 32'hDEADBEEF);

        applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0);
        checkOutput("byte_merge", last_rdata, 32'h11BB33DD);
        applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0);
        checkOutput("be_zero_noop", last_rdata, 32'h11BB33DD);

        applyStimulus(1'b0, 32'h12, 32'h0, 4'h0, 0);
        saved = model[0][0];
        applyStimulus(1'b1, 32'h200, 32'h5, 4'hF, 0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 0);
        checkOutput("oor_store_dropped", last_rdata, saved);

        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 4);
        checkOutput("backpressure_load", last_rdata, 32'hDEADBEEF);

        saved = model[0][12];
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h77;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("abort_in_wait_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(a_rsp_valid), 32'd0);
        checkOutput("abort_busy", 32'(a_busy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_rsp", 32'(a_rsp_valid), 32'd0);
        end
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0);
        checkOutput("abort_not_committed", last_rdata, saved);

        sel0 = 1'b1;
        applyStimulus(1'b1, 32'h30, 32'h77, 4'hF, 0);
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 2);
        checkOutput("lat0_load", last_rdata, 32'h77);
        applyStimulus(1'b0, 32'h33, 32'h0, 4'h0, 0);

        for (int t = 0; t < 300; t++) begin
            sel0 = 1'($urandom);
            case ($urandom_range(0, 9))
                0: addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                1: addr = $urandom | (32'd1 << $urandom_range(9, 31));
                default: addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            applyStimulus(1'($urandom), addr, $urandom, 4'($urandom),
                          int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
